// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register with hazard bubble insertion, branch flush, external freeze
// and saturating stall/flush performance counters.
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 4
`endif

module id_exe_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = `REG_FILE_ADDR_LEN,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned IMM_W      = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  hazard_detected,
  input  logic                  cnt_clr,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [OP_W-1:0]       op_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  b_in,
  input  logic                  is_imm_in,
  input  logic [DATA_W-1:0]     val1_in,
  input  logic [DATA_W-1:0]     val2_in,
  input  logic [IMM_W-1:0]      imm_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [OP_W-1:0]       op_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  b_out,
  output logic                  is_imm_out,
  output logic [DATA_W-1:0]     val1_out,
  output logic [DATA_W-1:0]     val2_out,
  output logic [IMM_W-1:0]      imm_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic capture;
  logic bubble;
  logic stall_inc;

  // Flush overrides freeze; a frozen cycle ignores the hazard entirely.
  assign capture   = flush | ~freeze;
  assign bubble    = flush | hazard_detected;
  assign stall_inc = hazard_detected & ~flush & ~freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out    <= 1'b0;
      pc_out       <= '0;
      op_out       <= '0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      b_out        <= 1'b0;
      is_imm_out   <= 1'b0;
      val1_out     <= '0;
      val2_out     <= '0;
      imm_out      <= '0;
      src1_out     <= '0;
      src2_out     <= '0;
      dest_out     <= '0;
    end else if (capture) begin
      valid_out    <= ~bubble;
      pc_out       <= bubble ? '0 : pc_in;
      op_out       <= bubble ? '0 : op_in;
      wb_en_out    <= ~bubble & wb_en_in;
      mem_r_en_out <= ~bubble & mem_r_en_in;
      mem_w_en_out <= ~bubble & mem_w_en_in;
      b_out        <= ~bubble & b_in;
      is_imm_out   <= ~bubble & is_imm_in;
      val1_out     <= bubble ? '0 : val1_in;
      val2_out     <= bubble ? '0 : val2_in;
      imm_out      <= bubble ? '0 : imm_in;
      src1_out     <= bubble ? '0 : src1_in;
      src2_out     <= bubble ? '0 : src2_in;
      dest_out     <= bubble ? '0 : dest_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1)     flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Bench for id_exe_pipe_reg: a rule-level model checked every negedge, plus directed
// literal expectations at the scenario checkpoints.
module tb_id_exe_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, freeze, hazard_detected, cnt_clr;
  logic [31:0] pc_in, val1_in, val2_in;
  logic [3:0]  op_in, src1_in, src2_in, dest_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, is_imm_in;
  logic [15:0] imm_in;

  logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, is_imm_out;
  logic [31:0] pc_out, val1_out, val2_out;
  logic [3:0]  op_out, src1_out, src2_out, dest_out;
  logic [15:0] imm_out, stall_cnt, flush_cnt;

  logic        v4, wb4, mr4, mw4, b4, ii4;
  logic [31:0] pc4, va4, vb4;
  logic [3:0]  op4, s14, s24, d4, stall4, flush4;
  logic [15:0] imm4;

  always #5 clk = ~clk;

  id_exe_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .hazard_detected(hazard_detected), .cnt_clr(cnt_clr),
    .pc_in(pc_in), .op_in(op_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .is_imm_in(is_imm_in),
    .val1_in(val1_in), .val2_in(val2_in), .imm_in(imm_in),
    .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
    .valid_out(valid_out), .pc_out(pc_out), .op_out(op_out), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .b_out(b_out),
    .is_imm_out(is_imm_out), .val1_out(val1_out), .val2_out(val2_out),
    .imm_out(imm_out), .src1_out(src1_out), .src2_out(src2_out), .dest_out(dest_out),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_exe_pipe_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .hazard_detected(hazard_detected), .cnt_clr(cnt_clr),
    .pc_in(pc_in), .op_in(op_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .is_imm_in(is_imm_in),
    .val1_in(val1_in), .val2_in(val2_in), .imm_in(imm_in),
    .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
    .valid_out(v4), .pc_out(pc4), .op_out(op4), .wb_en_out(wb4),
    .mem_r_en_out(mr4), .mem_w_en_out(mw4), .b_out(b4),
    .is_imm_out(ii4), .val1_out(va4), .val2_out(vb4),
    .imm_out(imm4), .src1_out(s14), .src2_out(s24), .dest_out(d4),
    .stall_cnt(stall4), .flush_cnt(flush4)
  );

  // Instruction as seen by EXE; an all-zero value is the bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  op;
    logic        wb, mr, mw, br, ii;
    logic [31:0] v1, v2;
    logic [15:0] imm;
    logic [3:0]  s1, s2, d;
  } instr_t;

  instr_t m_instr = '0;
  int     m_stall = 0, m_flush = 0;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  function automatic instr_t id_instr();
    return '{valid: 1'b1, pc: pc_in, op: op_in, wb: wb_en_in, mr: mem_r_en_in,
             mw: mem_w_en_in, br: b_in, ii: is_imm_in, v1: val1_in, v2: val2_in,
             imm: imm_in, s1: src1_in, s2: src2_in, d: dest_in};
  endfunction

  function automatic instr_t dut_instr();
    return '{valid: valid_out, pc: pc_out, op: op_out, wb: wb_en_out, mr: mem_r_en_out,
             mw: mem_w_en_out, br: b_out, ii: is_imm_out, v1: val1_out, v2: val2_out,
             imm: imm_out, s1: src1_out, s2: src2_out, d: dest_out};
  endfunction

  function automatic instr_t dut4_instr();
    return '{valid: v4, pc: pc4, op: op4, wb: wb4, mr: mr4, mw: mw4, br: b4, ii: ii4,
             v1: va4, v2: vb4, imm: imm4, s1: s14, s2: s24, d: d4};
  endfunction

  // Model: priority flush > freeze > hazard > load; counters as plain integers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_instr <= '0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (flush)                m_instr <= '0;
      else if (!freeze)         m_instr <= hazard_detected ? instr_t'(0) : id_instr();
      if (cnt_clr) begin
        m_stall <= 0;
        m_flush <= 0;
      end else begin
        if (hazard_detected && !flush && !freeze) m_stall <= m_stall + 1;
        if (flush)                                m_flush <= m_flush + 1;
      end
    end
  end

  function automatic int sat(int v, int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("instr", 160'(dut_instr()), 160'(m_instr));
      check("instr_cnt4", 160'(dut4_instr()), 160'(m_instr));
      check("stall_cnt", 160'(stall_cnt), 160'(sat(m_stall, 65535)));
      check("flush_cnt", 160'(flush_cnt), 160'(sat(m_flush, 65535)));
      check("stall_cnt4", 160'(stall4), 160'(sat(m_stall, 15)));
      check("flush_cnt4", 160'(flush4), 160'(sat(m_flush, 15)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {flush, freeze, hazard_detected, cnt_clr} = '0;
    pc_in = '0; op_in = '0; val1_in = '0; val2_in = '0; imm_in = '0;
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, is_imm_in} = '0;
    src1_in = '0; src2_in = '0; dest_in = '0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    check_en = 1'b1;
    check("rst_valid", 160'(valid_out), 160'(0));
    check("rst_stall", 160'(stall_cnt), 160'(0));

    // Plain capture after reset release
    rst = 1'b0;
    pc_in = 32'h10; wb_en_in = 1'b1; dest_in = 4'd3;
    step();
    check("t1_valid", 160'(valid_out), 160'(1));
    check("t1_pc", 160'(pc_out), 160'(32'h10));
    check("t1_dest", 160'(dest_out), 160'(3));
    check("t1_wb", 160'(wb_en_out), 160'(1));

    // Two hazard cycles with a load waiting
    pc_in = 32'h20; op_in = 4'd4; mem_r_en_in = 1'b1; dest_in = 4'd5; src1_in = 4'd2;
    val1_in = 32'h1234; imm_in = 16'd8; is_imm_in = 1'b1; hazard_detected = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("t2_bub_valid", 160'(valid_out), 160'(0));
      check("t2_bub_wb", 160'(wb_en_out), 160'(0));
      check("t2_bub_mr", 160'(mem_r_en_out), 160'(0));
    end
    hazard_detected = 1'b0;
    step();
    check("t2_load_valid", 160'(valid_out), 160'(1));
    check("t2_load_mr", 160'(mem_r_en_out), 160'(1));
    check("t2_load_pc", 160'(pc_out), 160'(32'h20));
    check("t2_stall", 160'(stall_cnt), 160'(2));

    // Flush beats hazard, then flush beats freeze
    flush = 1'b1; hazard_detected = 1'b1;
    step();
    check("t3a_valid", 160'(valid_out), 160'(0));
    check("t3a_flush", 160'(flush_cnt), 160'(1));
    hazard_detected = 1'b0; freeze = 1'b1;
    step();
    check("t3b_valid", 160'(valid_out), 160'(0));
    check("t3b_pc", 160'(pc_out), 160'(0));
    check("t3b_flush", 160'(flush_cnt), 160'(2));
    check("t3b_stall", 160'(stall_cnt), 160'(2));

    // Freeze holds everything and ignores hazards
    flush = 1'b0; freeze = 1'b0;
    pc_in = 32'h30; op_in = 4'd7; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1; val2_in = 32'hbeef;
    step();
    check("t4_pre_pc", 160'(pc_out), 160'(32'h30));
    freeze = 1'b1; hazard_detected = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'h100 + 32'(i); val2_in = 32'h55 + 32'(i); mem_w_en_in = 1'b0;
      step();
      check("t4_hold_pc", 160'(pc_out), 160'(32'h30));
      check("t4_hold_mw", 160'(mem_w_en_out), 160'(1));
      check("t4_hold_v2", 160'(val2_out), 160'(32'hbeef));
      check("t4_stall", 160'(stall_cnt), 160'(2));
    end

    // Saturation on the 4-bit counters, then clear racing a hazard
    freeze = 1'b0; hazard_detected = 1'b0; cnt_clr = 1'b1;
    step();
    check("t5_clr", 160'(stall4), 160'(0));
    cnt_clr = 1'b0; hazard_detected = 1'b1;
    for (int i = 0; i < 17; i++) step();
    check("t5_sat4", 160'(stall4), 160'(15));
    check("t5_stall16", 160'(stall_cnt), 160'(17));
    cnt_clr = 1'b1;
    step();
    check("t5_clr4", 160'(stall4), 160'(0));
    check("t5_clr16", 160'(stall_cnt), 160'(0));

    // Asynchronous reset mid-cycle
    cnt_clr = 1'b0; hazard_detected = 1'b0; pc_in = 32'h40; b_in = 1'b1;
    step();
    check("t6_pre_valid", 160'(valid_out), 160'(1));
    #2 rst = 1'b1;
    #1;
    check("t6_valid", 160'(valid_out), 160'(0));
    check("t6_pc", 160'(pc_out), 160'(0));
    check("t6_b", 160'(b_out), 160'(0));
    step();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
